// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
//
// Six-digit, time-multiplexed seven-segment driver for a common-anode display.
// It reads the BCD time digits from the clock core and shows them one digit at
// a time. The six digits are captured once per frame, so a frame never shows a
// time that changed part-way through the scan. Each digit slot opens with a
// short gap where every anode is off, which stops ghosting on the next digit.
// The minute or hour field blinks while that field is being set.
//
// Parameters
//   SCAN_DIV  : clk cycles per digit slot (>= 2)
//   BLANK_CYC : gap cycles at the start of each slot, all anodes off
//               (0 .. SCAN_DIV-1)
//   BLINK_DIV : clk cycles per blink half-period (>= 1)
//   LZ_BLANK  : 1 shows a leading zero in hour_10 as a blank digit
//
// Ports
//   clk              : display scan clock
//   clr_n            : synchronous active-low reset
//   sec_01 .. hour_10: BCD time digits from the clock core (live)
//   blink_min        : minute field being set, blink min_10/min_01
//   blink_hour       : hour field being set, blink hour_10/hour_01
//   an_n[5:0]        : digit anodes, active-low, at most one low
//   seg_n[6:0]       : segments {g,f,e,d,c,b,a}, active-low
//   dp_n             : decimal point used as colon, active-low
// -----------------------------------------------------------------------------
module seg7_scan_display #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16,
    parameter int BLINK_DIV = 250000,
    parameter int LZ_BLANK  = 1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] sec_01,
    input  logic [3:0] sec_10,
    input  logic [3:0] min_01,
    input  logic [3:0] min_10,
    input  logic [3:0] hour_01,
    input  logic [3:0] hour_10,
    input  logic       blink_min,
    input  logic       blink_hour,
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic               LZ_EN      = (LZ_BLANK != 0);

    // Slot numbering: the anode bit and the snapshot nibble share the index.
    localparam logic [2:0] SLOT_SEC_01  = 3'd0;
    localparam logic [2:0] SLOT_SEC_10  = 3'd1;
    localparam logic [2:0] SLOT_MIN_01  = 3'd2;
    localparam logic [2:0] SLOT_MIN_10  = 3'd3;
    localparam logic [2:0] SLOT_HOUR_01 = 3'd4;
    localparam logic [2:0] SLOT_HOUR_10 = 3'd5;

    localparam logic [5:0] AN_ALL_OFF  = 6'h3F;
    localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

    // BCD to active-low segment code; non-BCD values show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h3F;
        endcase
        return code;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [2:0]         idx_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               phase_r;
    logic [23:0]        snap_r;

    logic               scan_last_s;
    logic               frame_last_s;
    logic               in_gap_s;
    logic [3:0]         digit_s;
    logic               is_min_s;
    logic               is_hour_s;
    logic               blank_s;
    logic               colon_s;
    logic [5:0]         an_nxt_s;
    logic [6:0]         seg_nxt_s;
    logic               dp_nxt_s;

    assign scan_last_s  = (scan_cnt_r == SCAN_LAST);
    assign frame_last_s = scan_last_s && (idx_r == SLOT_HOUR_10);

    // The gap compare only exists when a gap is configured.
    generate
        if (BLANK_CYC > 0) begin : g_gap
            localparam logic [SCAN_W-1:0] BLANK_LIM = SCAN_W'(BLANK_CYC);
            assign in_gap_s = (scan_cnt_r < BLANK_LIM);
        end else begin : g_no_gap
            assign in_gap_s = 1'b0;
        end
    endgenerate

    // Select the snapshot nibble for the current slot.
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            SLOT_SEC_01:  digit_s = snap_r[3:0];
            SLOT_SEC_10:  digit_s = snap_r[7:4];
            SLOT_MIN_01:  digit_s = snap_r[11:8];
            SLOT_MIN_10:  digit_s = snap_r[15:12];
            SLOT_HOUR_01: digit_s = snap_r[19:16];
            SLOT_HOUR_10: digit_s = snap_r[23:20];
            default:      digit_s = 4'd0;
        endcase
    end

    assign is_min_s  = (idx_r == SLOT_MIN_01)  || (idx_r == SLOT_MIN_10);
    assign is_hour_s = (idx_r == SLOT_HOUR_01) || (idx_r == SLOT_HOUR_10);

    // Blink uses the live field-select inputs; only the digits are frozen.
    assign blank_s = (!phase_r && ((is_min_s && blink_min) || (is_hour_s && blink_hour)))
                  || (LZ_EN && (idx_r == SLOT_HOUR_10) && (digit_s == 4'd0));

    assign colon_s = ((idx_r == SLOT_HOUR_01) || (idx_r == SLOT_MIN_01))
                  && phase_r && !blank_s;

    // Next output values, registered below so outputs lag state by one cycle.
    always_comb begin
        an_nxt_s  = AN_ALL_OFF;
        seg_nxt_s = SEG_ALL_OFF;
        dp_nxt_s  = 1'b1;
        if (in_gap_s) begin
            an_nxt_s  = AN_ALL_OFF;
            seg_nxt_s = SEG_ALL_OFF;
            dp_nxt_s  = 1'b1;
        end else begin
            an_nxt_s = ~(6'b00_0001 << idx_r);
            if (blank_s) begin
                seg_nxt_s = SEG_ALL_OFF;
                dp_nxt_s  = 1'b1;
            end else begin
                seg_nxt_s = seg_decode(digit_s);
                dp_nxt_s  = ~colon_s;
            end
        end
    end

    // Slot counter, digit index and the once-per-frame digit snapshot.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            scan_cnt_r <= '0;
            idx_r      <= 3'd0;
            snap_r     <= 24'd0;
        end else if (scan_last_s) begin
            scan_cnt_r <= '0;
            if (frame_last_s) begin
                idx_r  <= 3'd0;
                snap_r <= {hour_10, hour_01, min_10, min_01, sec_10, sec_01};
            end else begin
                idx_r  <= idx_r + 3'd1;
                snap_r <= snap_r;
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            idx_r      <= idx_r;
            snap_r     <= snap_r;
        end
    end

    // Blink half-period counter; phase 1 is the visible half.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
            phase_r     <= phase_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            an_n  <= AN_ALL_OFF;
            seg_n <= SEG_ALL_OFF;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= an_nxt_s;
            seg_n <= seg_nxt_s;
            dp_n  <= dp_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_display
//
// Two instances share the stimulus: A (SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=8,
// LZ_BLANK=1) and B (SCAN_DIV=3, BLANK_CYC=0, BLINK_DIV=5, LZ_BLANK=0).
// Each cycle the expected outputs of both are derived from the cycle count
// since reset and pushed to a queue; a monitor pops and compares them after the
// clock edge. The scenario tasks add targeted checks of their own.
// -----------------------------------------------------------------------------
module tb_seg7_scan_display;

    localparam int A_SD = 4, A_BC = 1, A_BD = 8, A_LZ = 1;
    localparam int B_SD = 3, B_BC = 0, B_BD = 5, B_LZ = 0;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] sec_01, sec_10, min_01, min_10, hour_01, hour_10;
    logic       blink_min, blink_hour;
    logic [5:0] an_n_a, an_n_b;
    logic [6:0] seg_n_a, seg_n_b;
    logic       dp_n_a, dp_n_b;

    always #5 clk = ~clk;

    seg7_scan_display #(.SCAN_DIV(A_SD), .BLANK_CYC(A_BC), .BLINK_DIV(A_BD), .LZ_BLANK(A_LZ)) dut_a (
        .clk(clk), .clr_n(clr_n),
        .sec_01(sec_01), .sec_10(sec_10), .min_01(min_01), .min_10(min_10),
        .hour_01(hour_01), .hour_10(hour_10),
        .blink_min(blink_min), .blink_hour(blink_hour),
        .an_n(an_n_a), .seg_n(seg_n_a), .dp_n(dp_n_a)
    );

    seg7_scan_display #(.SCAN_DIV(B_SD), .BLANK_CYC(B_BC), .BLINK_DIV(B_BD), .LZ_BLANK(B_LZ)) dut_b (
        .clk(clk), .clr_n(clr_n),
        .sec_01(sec_01), .sec_10(sec_10), .min_01(min_01), .min_10(min_10),
        .hour_01(hour_01), .hour_10(hour_10),
        .blink_min(blink_min), .blink_hour(blink_hour),
        .an_n(an_n_b), .seg_n(seg_n_b), .dp_n(dp_n_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [23:0] snap_a   = 24'd0;
    logic [23:0] snap_b   = 24'd0;
    logic [27:0] sb_q[$];
    logic [27:0] mon_exp, mon_got;
    logic [6:0]  seen_a[6];
    logic [6:0]  seen_b[6];

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected {an_n, seg_n, dp_n} after the edge that ends cycle c since reset.
    function automatic logic [13:0] ref_out(input int c, input int sd, input int bc,
                                            input int bd, input int lz,
                                            input logic [23:0] snap,
                                            input logic bm, input logic bh);
        int         scan, idx;
        logic       phase, blank;
        logic [3:0] d;
        logic [5:0] an;
        scan  = c % sd;
        idx   = (c / sd) % 6;
        phase = (((c / bd) % 2) == 0);
        if (scan < bc) return {6'h3F, 7'h7F, 1'b1};
        d       = snap[idx*4 +: 4];
        an      = 6'h3F;
        an[idx] = 1'b0;
        blank = (!phase && (idx == 2 || idx == 3) && bm)
             || (!phase && (idx == 4 || idx == 5) && bh)
             || (lz != 0 && idx == 5 && d == 4'd0);
        if (blank) return {an, 7'h7F, 1'b1};
        return {an, ref_seg(d), !((idx == 2 || idx == 4) && phase)};
    endfunction

    // Scoreboard monitor: compare the queued expectation just after each edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_got = {an_n_a, seg_n_a, dp_n_a, an_n_b, seg_n_b, dp_n_b};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL scoreboard cyc=%0d: got A=%h B=%h, expected A=%h B=%h",
                         cyc, mon_got[27:14], mon_got[13:0], mon_exp[27:14], mon_exp[13:0]);
            end
        end
    end

    // One clock: queue the expectation, let the edge happen, advance the model.
    task automatic tick();
        logic [23:0] in_v;
        in_v = {hour_10, hour_01, min_10, min_01, sec_10, sec_01};
        if (!clr_n)
            sb_q.push_back(28'hFFF_FFFF);
        else
            sb_q.push_back({ref_out(cyc, A_SD, A_BC, A_BD, A_LZ, snap_a, blink_min, blink_hour),
                            ref_out(cyc, B_SD, B_BC, B_BD, B_LZ, snap_b, blink_min, blink_hour)});
        @(posedge clk);
        if (!clr_n) begin
            cyc    = 0;
            snap_a = 24'd0;
            snap_b = 24'd0;
        end else begin
            if (cyc % (6 * A_SD) == 6 * A_SD - 1) snap_a = in_v;
            if (cyc % (6 * B_SD) == 6 * B_SD - 1) snap_b = in_v;
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour_10 = 4'(h / 10); hour_01 = 4'(h % 10);
        min_10  = 4'(m / 10); min_01  = 4'(m % 10);
        sec_10  = 4'(s / 10); sec_01  = 4'(s % 10);
    endtask

    // Tick n times, remembering the last visible segment code of each slot.
    task automatic tick_record(input int n);
        for (int k = 0; k < 6; k++) begin
            seen_a[k] = 7'h7E;
            seen_b[k] = 7'h7E;
        end
        for (int i = 0; i < n; i++) begin
            tick();
            for (int k = 0; k < 6; k++) begin
                if (an_n_a == ~(6'b00_0001 << k)) seen_a[k] = seg_n_a;
                if (an_n_b == ~(6'b00_0001 << k)) seen_b[k] = seg_n_b;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        set_time(12, 34, 56);
        blink_min  = 1'b0;
        blink_hour = 1'b0;
        clr_n      = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({an_n_a, seg_n_a, dp_n_a} !== 14'h3FFF || {an_n_b, seg_n_b, dp_n_b} !== 14'h3FFF) begin
            n_fail++;
            $display("FAIL reset_outputs: got A=%h B=%h, expected 3fff", {an_n_a, seg_n_a, dp_n_a}, {an_n_b, seg_n_b, dp_n_b});
        end
        clr_n = 1'b1;
        tick();
        n_checks++;
        if (an_n_b !== 6'h3E || seg_n_b !== 7'h40) begin
            n_fail++;
            $display("FAIL first_digit_no_gap: got an=%h seg=%h, expected an=3e seg=40", an_n_b, seg_n_b);
        end
        bad = 0;
        for (int i = 1; i < 6 * A_SD; i++) begin
            tick();
            if (an_n_a == 6'h1F && seg_n_a !== 7'h7F) bad++;
            if (an_n_a != 6'h1F && an_n_a != 6'h3F && seg_n_a !== 7'h40) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL first_frame_zeros: got %0d wrong cycles, expected 0", bad);
        end
    endtask

    task automatic test_static_scan();
        logic [6:0] dig_seg[6];
        logic [5:0] an_e;
        logic [6:0] seg_e;
        int         j, s;
        dig_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        for (int i = 0; i < 6 * A_SD; i++) begin
            tick();
            j = (cyc - 1) % (6 * A_SD);
            s = j / A_SD;
            an_e  = 6'h3F;
            seg_e = 7'h7F;
            if (j % A_SD != 0) begin
                an_e[s] = 1'b0;
                seg_e   = dig_seg[s];
            end
            n_checks++;
            if (an_n_a !== an_e || seg_n_a !== seg_e) begin
                n_fail++;
                $display("FAIL static_scan[%0d]: got an=%h seg=%h, expected an=%h seg=%h", j, an_n_a, seg_n_a, an_e, seg_e);
            end
        end
    endtask

    task automatic test_snapshot_coherency();
        set_time(12, 34, 59);
        repeat (6 * A_SD) tick();
        for (int i = 0; i < 48 && (cyc % (6 * A_SD)) != 9; i++) tick();
        set_time(12, 35, 0);
        tick_record(6 * A_SD - (cyc % (6 * A_SD)));
        n_checks++;
        if (seen_a[2] !== 7'h19 || seen_a[3] !== 7'h30) begin
            n_fail++;
            $display("FAIL snapshot_hold: got min=%h/%h, expected 19/30", seen_a[3], seen_a[2]);
        end
        tick_record(6 * A_SD);
        n_checks++;
        if (seen_a[0] !== 7'h40 || seen_a[1] !== 7'h40 || seen_a[2] !== 7'h12 || seen_a[3] !== 7'h30) begin
            n_fail++;
            $display("FAIL snapshot_next: got %h %h %h %h, expected 30 12 40 40", seen_a[3], seen_a[2], seen_a[1], seen_a[0]);
        end
    endtask

    task automatic test_blink();
        int gaps, hour_blank, hour_vis, other_blank;
        blink_hour = 1'b1;
        gaps = 0; hour_blank = 0; hour_vis = 0; other_blank = 0;
        for (int i = 0; i < 12 * A_SD; i++) begin
            tick();
            if (an_n_a == 6'h3F) gaps++;
            else if (an_n_a == 6'h2F || an_n_a == 6'h1F) begin
                if (seg_n_a == 7'h7F) hour_blank++; else hour_vis++;
            end else if (seg_n_a == 7'h7F) other_blank++;
        end
        n_checks++;
        if (gaps != 12) begin
            n_fail++;
            $display("FAIL blink_scan_gaps: got %0d, expected 12", gaps);
        end
        n_checks++;
        if (hour_blank == 0 || hour_vis == 0 || other_blank != 0) begin
            n_fail++;
            $display("FAIL blink_hour: got blank=%0d vis=%0d other=%0d, expected >0 >0 0", hour_blank, hour_vis, other_blank);
        end
        blink_hour = 1'b0;
        blink_min  = 1'b1;
        repeat (6 * A_SD) tick();
        blink_min = 1'b0;
    endtask

    task automatic test_invalid_bcd();
        sec_01  = 4'hB;
        hour_10 = 4'd0;
        repeat (12 * A_SD) tick();
        tick_record(6 * A_SD);
        n_checks++;
        if (seen_a[0] !== 7'h3F || seen_b[0] !== 7'h3F) begin
            n_fail++;
            $display("FAIL invalid_bcd: got A=%h B=%h, expected 3f", seen_a[0], seen_b[0]);
        end
        n_checks++;
        if (seen_a[5] !== 7'h7F || seen_b[5] !== 7'h40) begin
            n_fail++;
            $display("FAIL leading_zero: got A=%h B=%h, expected A=7f B=40", seen_a[5], seen_b[5]);
        end
    endtask

    task automatic test_reset_mid();
        int tries;
        blink_min  = 1'b1;
        blink_hour = 1'b1;
        tries = 0;
        while (!((cyc % 24) == 14 && ((cyc / A_BD) % 2) == 1) && tries < 200) begin
            tick();
            tries++;
        end
        n_checks++;
        if (tries >= 200) begin
            n_fail++;
            $display("FAIL mid_reset_search: got no idx=3 phase=0 point, expected one within 200 cycles");
        end
        clr_n = 1'b0;
        tick();
        n_checks++;
        if ({an_n_a, seg_n_a, dp_n_a} !== 14'h3FFF || {an_n_b, seg_n_b, dp_n_b} !== 14'h3FFF) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got A=%h B=%h, expected 3fff", {an_n_a, seg_n_a, dp_n_a}, {an_n_b, seg_n_b, dp_n_b});
        end
        clr_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (an_n_a !== 6'h3E || seg_n_a !== 7'h40) begin
            n_fail++;
            $display("FAIL mid_reset_restart: got an=%h seg=%h, expected an=3e seg=40", an_n_a, seg_n_a);
        end
        repeat (12 * A_SD) tick();
        blink_min  = 1'b0;
        blink_hour = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static_scan();
        test_snapshot_coherency();
        test_blink();
        test_invalid_bcd();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
